// File: rtl/pll_seq_pkg.sv
// ============================================================================
// pll_seq_pkg : shared state encoding and default widths for the PLL sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pll_seq_pkg;

  localparam int unsigned DEF_DIV_W  = 5;
  localparam int unsigned DEF_TRIM_W = 26;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUX_EXT = 3'd1,
    ST_PLL_OFF = 3'd2,
    ST_LOAD    = 3'd3,
    ST_PLL_ON  = 3'd4,
    ST_SETTLE  = 3'd5,
    ST_MUX_PLL = 3'd6,
    ST_DONE    = 3'd7
  } pll_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/pll_seq_timer.sv
// ============================================================================
// pll_seq_timer : shared non-wrapping wait counter; expired flags the last cycle
// Revision      : 1.0
// ============================================================================
`default_nettype none

module pll_seq_timer
  import pll_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] load,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loaded with N on entry to a wait state, so the state lasts N cycles (N..1).
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = load;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/pll_sequencer.sv
// ============================================================================
// pll_sequencer : glitch-safe PLL reconfiguration sequencer (optional abort
//                 input under macro PLL_SEQ_ABORT_EN)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module pll_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned DIV_W         = DEF_DIV_W,
  parameter int unsigned TRIM_W        = DEF_TRIM_W,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned GUARD_CYCLES  = 4
) (
  input  logic              clock,
  input  logic              reset,
`ifdef PLL_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [TRIM_W-1:0] cfg_trim,
  input  logic              cfg_use_pll,
  output logic              pll_ena,
  output logic              pll_dco,
  output logic [DIV_W-1:0]  pll_div,
  output logic [TRIM_W-1:0] pll_trim,
  output logic              sel_pll,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_CYCLES);

  pll_seq_state_t    state_q, state_d;
  logic              use_pll_q;
  logic [DIV_W-1:0]  div_cap_q, pll_div_q;
  logic [TRIM_W-1:0] trim_cap_q, pll_trim_q;
  logic              sel_pll_q, pll_ena_q;
  logic              tmr_start, tmr_expired;
  logic [CNT_W-1:0]  tmr_load;
`ifdef PLL_SEQ_ABORT_EN
  logic              abort_q, abort_d;
`endif

  pll_seq_timer u_timer (
    .clock   (clock),
    .reset   (reset),
    .start   (tmr_start),
    .load    (tmr_load),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    tmr_start = 1'b0;
    tmr_load  = GUARD_LD;
`ifdef PLL_SEQ_ABORT_EN
    abort_d   = abort_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          state_d   = ST_MUX_EXT;
          tmr_start = 1'b1;
        end
      end
      ST_MUX_EXT: if (tmr_expired) state_d = ST_PLL_OFF;
      ST_PLL_OFF: begin
`ifdef PLL_SEQ_ABORT_EN
        state_d = abort_q ? ST_IDLE : ST_LOAD;
        abort_d = 1'b0;
`else
        state_d = ST_LOAD;
`endif
      end
      ST_LOAD:    state_d = use_pll_q ? ST_PLL_ON : ST_DONE;
      ST_PLL_ON: begin
        state_d   = ST_SETTLE;
        tmr_start = 1'b1;
        tmr_load  = SETTLE_LD;
      end
      ST_SETTLE: begin
        if (tmr_expired) begin
          state_d   = ST_MUX_PLL;
          tmr_start = 1'b1;
        end
      end
      ST_MUX_PLL: if (tmr_expired) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
`ifdef PLL_SEQ_ABORT_EN
    // An abort already inside MUX_EXT just finishes the running guard wait.
    if (abort && !abort_q && state_q != ST_IDLE && state_q != ST_DONE) begin
      abort_d = 1'b1;
      if (state_q != ST_MUX_EXT) begin
        state_d   = ST_MUX_EXT;
        tmr_start = 1'b1;
        tmr_load  = GUARD_LD;
      end
    end
`endif
  end

  // Outputs change on entry to the state that owns them, so each is steady for the whole state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      use_pll_q  <= 1'b0;
      div_cap_q  <= '0;
      trim_cap_q <= '0;
      pll_div_q  <= '0;
      pll_trim_q <= '0;
      sel_pll_q  <= 1'b0;
      pll_ena_q  <= 1'b0;
`ifdef PLL_SEQ_ABORT_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef PLL_SEQ_ABORT_EN
      abort_q <= abort_d;
`endif
      if (state_q == ST_IDLE && cfg_valid) begin
        use_pll_q  <= cfg_use_pll;
        div_cap_q  <= cfg_div;
        trim_cap_q <= cfg_trim;
      end
      if (state_d == ST_MUX_EXT) sel_pll_q <= 1'b0;
      if (state_d == ST_PLL_OFF) pll_ena_q <= 1'b0;
      if (state_d == ST_LOAD) begin
        pll_div_q  <= div_cap_q;
        pll_trim_q <= trim_cap_q;
      end
      if (state_d == ST_PLL_ON)  pll_ena_q <= 1'b1;
      if (state_d == ST_MUX_PLL) sel_pll_q <= 1'b1;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pll_ena   = pll_ena_q;
  assign pll_dco   = pll_ena_q;
  assign pll_div   = pll_div_q;
  assign pll_trim  = pll_trim_q;
  assign sel_pll   = sel_pll_q;

endmodule

`default_nettype wire
